ysyx_25040111_rr_arbiter: RTL and testbench
===========================================

YSYX_25040111_RR_ARBITER -- requirements
Module: ysyx_25040111_rr_arbiter

Interface
REQ-001 SHALL provide parameters:
- N_REQ, default 2: number of requesters, 2..8.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
- LEN_W, default 8: burst length field width, value = beats-1.
REQ-002 SHALL provide these ports (clock and reset first):
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accepted, one-hot pulse.
- req_write  in  N_REQ  1=write, 0=read.
- req_burst  in  N_REQ  read burst enable.
- req_addr  in  N_REQ*ADDR_W  flattened; slice i = requester i.
- req_wdata  in  N_REQ*DATA_W  flattened write data.
- req_mask  in  N_REQ*2  flattened size: 00 byte, 01 half, 10/11 word.
- req_len  in  N_REQ*LEN_W  flattened burst length.
- resp_valid  out  N_REQ  one-hot response beat strobe.
- resp_data  out  DATA_W  shared read data.
- resp_last  out  1  final beat of the current response.
- m_valid  out  1  downstream command valid.
- m_ready  in  1  downstream command accept.
- m_write, m_burst  out  1  latched command type.
- m_addr  out  ADDR_W  latched address.
- m_wdata  out  DATA_W  latched write data.
- m_mask  out  2  latched size.
- m_len  out  LEN_W  latched length; forced 0 when m_burst=0.
- m_rvalid  in  1  read beat valid.
- m_rdata  in  DATA_W  read beat data.
- m_rlast  in  1  last read beat.

Function
REQ-003 SHALL implement FSM IDLE -> CMD -> (write: IDLE | read: RESP -> IDLE).
REQ-004 In IDLE with any req_valid set, SHALL select winner g, pulse req_ready[g] for exactly that cycle, latch g and requester g's fields, and enter CMD on the next edge.
REQ-005 Round-robin selection: search starts at ptr and wraps N_REQ-1 -> 0; after completion ptr = (g+1) mod N_REQ, so N_REQ-1 wraps to 0.
REQ-006 In CMD, m_valid=1 with latched fields held stable until m_valid&m_ready.
REQ-007 On a write handshake SHALL pulse resp_valid[g] with resp_last=1 in the same cycle, return to IDLE, and update ptr.
REQ-008 On a read handshake SHALL enter RESP.
REQ-009 In RESP, each m_rvalid SHALL drive resp_valid[g]=1, resp_data=m_rdata, resp_last=m_rlast combinationally, zero latency.
REQ-010 m_rvalid&m_rlast in RESP SHALL return the FSM to IDLE and update ptr.
REQ-011 A beat counter SHALL count RESP beats; reaching m_len beats without m_rlast SHALL also terminate the transaction, with resp_last forced 1 on that beat.
REQ-012 m_rvalid outside RESP SHALL be ignored: no resp_valid asserted.
REQ-013 A new grant SHALL NOT be issued before the FSM returns to IDLE; minimum transaction is 2 cycles, accept plus CMD.
REQ-014 A requester deasserting req_valid after acceptance SHALL NOT affect the in-flight transaction.
REQ-015 Outside their active states: m_valid=0, resp_valid=0, req_ready=0, resp_data=0.

Reset
REQ-016 Asserting reset at any time, including mid-transaction, SHALL immediately force IDLE, ptr=0, beat counter=0, all latched fields=0, and all outputs=0.
REQ-017 The first grant after reset release SHALL be decided by the lowest-index requester at or after ptr=0.

Configuration
REQ-018 Macro YSYX_25040111_ARB_FIXED_PRIO0_EN, when defined, SHALL give requester 0 strict priority: whenever req_valid[0] is set in IDLE it wins; the remaining requesters use round-robin among themselves.
REQ-019 Without the macro, pure round-robin across all N_REQ requesters SHALL apply.

Verification
REQ-020 N_REQ=2, req_valid=2'b11 continuously, all writes, m_ready=1 -> grants alternate 0,1,0,1; one req_ready pulse every 2 cycles.
REQ-021 Read, req_addr[0]=0x8000_0000, burst=1, len=3, m_rdata 0xA..0xD -> resp_valid[0] on 4 beats; resp_last only on the 0xD beat.
REQ-022 Write with m_ready held 0 for 5 cycles -> m_valid and m_addr stable all 5 cycles; completes on cycle 6.
REQ-023 Reset asserted in RESP after beat 2 of 4 -> outputs 0 without waiting for an edge; the next request is granted from ptr=0.
REQ-024 N_REQ=4, only req 3 then req 0 valid -> grant 3, then 0 (wrap); with the macro defined and req 0 and req 2 both valid -> req 0 always granted first.
REQ-025 Stray m_rvalid=1 in IDLE -> resp_valid stays 0.

Source files
------------

// File: rtl/ysyx_25040111_rr_arbiter.sv
// Round-robin N-to-1 bus arbiter: grant, command hand-off, and response routing back to the winner.
// Optional macro YSYX_25040111_ARB_FIXED_PRIO0_EN gives requester 0 strict priority over a round-robin of the rest.
module ysyx_25040111_rr_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ-1:0]          req_burst,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*2-1:0]        req_mask,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_write,
  output logic                      m_burst,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [1:0]                m_mask,
  output logic [LEN_W-1:0]          m_len,
  input  logic                      m_rvalid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_rlast
);

  localparam int          PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR    = N_REQ;
  localparam logic [N_REQ-1:0] ONE = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  nxt_ptr;
  logic              any_req;
  logic [LEN_W-1:0]  beat_cnt;
  logic              beat_end;

  logic              lat_write;
  logic              lat_burst;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        lat_mask;
  logic [LEN_W-1:0]  lat_len;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [1:0]        mask_arr  [N_REQ];
  logic [LEN_W-1:0]  len_arr   [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    assign mask_arr[i]  = req_mask[i*2 +: 2];
    assign len_arr[i]   = req_len[i*LEN_W +: LEN_W];
  end

  // First set bit of v scanning upward from start, wrapping N_REQ-1 -> 0.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] pick;
    logic             found;
    int unsigned      cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = 32'(start) + k;
      if (cand >= NR) cand = cand - NR;
      if (!found && v[PTR_W'(cand)]) begin
        found = 1'b1;
        pick  = PTR_W'(cand);
      end
    end
    return pick;
  endfunction

  assign any_req = |req_valid;

`ifdef YSYX_25040111_ARB_FIXED_PRIO0_EN
  // Bit 0 is masked out of the rotation so the others share round-robin among themselves.
  assign win = req_valid[0] ? '0 : rr_pick(req_valid & ~ONE, ptr);
`else
  assign win = rr_pick(req_valid, ptr);
`endif

  assign nxt_ptr  = (gnt == PTR_W'(N_REQ - 1)) ? '0 : gnt + PTR_W'(1);
  assign beat_end = m_rlast || (beat_cnt == lat_len);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      beat_cnt  <= '0;
      lat_write <= 1'b0;
      lat_burst <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
      lat_len   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state     <= S_CMD;
            gnt       <= win;
            lat_write <= req_write[win];
            lat_burst <= req_burst[win];
            lat_addr  <= addr_arr[win];
            lat_wdata <= wdata_arr[win];
            lat_mask  <= mask_arr[win];
            lat_len   <= req_burst[win] ? len_arr[win] : '0;
          end
        end
        S_CMD: begin
          if (m_ready) begin
            beat_cnt <= '0;
            if (lat_write) begin
              state <= S_IDLE;
              ptr   <= nxt_ptr;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (m_rvalid) begin
            if (beat_end) begin
              state    <= S_IDLE;
              ptr      <= nxt_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are additionally gated by reset so they drop the instant reset rises.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_last  = 1'b0;
    m_valid    = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (any_req) req_ready = ONE << win;
        end
        S_CMD: begin
          m_valid = 1'b1;
          if (m_ready && lat_write) begin
            resp_valid = ONE << gnt;
            resp_last  = 1'b1;
          end
        end
        S_RESP: begin
          if (m_rvalid) begin
            resp_valid = ONE << gnt;
            resp_data  = m_rdata;
            resp_last  = beat_end;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_write = lat_write;
  assign m_burst = lat_burst;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign m_mask  = lat_mask;
  assign m_len   = lat_len;

endmodule

// File: tb/tb_ysyx_25040111_rr_arbiter.sv
// Bench for ysyx_25040111_rr_arbiter (N_REQ=4): directed scenarios plus randomized transactions
// checked against a behavioural arbitration/transaction model.
module tb_ysyx_25040111_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_write, req_burst, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*2-1:0]  req_mask;
  logic [N*LW-1:0] req_len;
  logic [DW-1:0]   resp_data, m_wdata, m_rdata;
  logic            resp_last, m_valid, m_ready, m_write, m_burst, m_rvalid, m_rlast;
  logic [AW-1:0]   m_addr;
  logic [1:0]      m_mask;
  logic [LW-1:0]   m_len;

  always #5 clock = ~clock;

  ysyx_25040111_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_burst(req_burst),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .req_len(req_len),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_burst(m_burst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask), .m_len(m_len),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast)
  );

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  int          e_g;
  logic        e_write, e_burst;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_mask;
  logic [7:0]  e_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rotated visiting order starting at the pointer; first valid entry wins.
  function automatic int model_pick(input logic [3:0] v, input int p);
    int order[$];
`ifdef YSYX_25040111_ARB_FIXED_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[j]) begin
`ifdef YSYX_25040111_ARB_FIXED_PRIO0_EN
      if (order[j] == 0) continue;
`endif
      if (((v >> order[j]) & 4'd1) != 4'd0) return order[j];
    end
    return -1;
  endfunction

  // mode: 0 random type, 1 all writes, 2 all reads
  task automatic rand_fields(input int mode);
    for (int i = 0; i < N; i++) begin
      req_write[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      req_burst[i] = 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW]  = $urandom;
      req_wdata[i*DW +: DW] = $urandom;
      req_mask[i*2 +: 2]    = 2'($urandom_range(0, 3));
      req_len[i*LW +: LW]   = 8'($urandom_range(0, 4));
    end
  endtask

  task automatic grant(input logic [3:0] v, input bit keep, input int mode);
    req_valid = v;
    #1;
    e_g = model_pick(v, ptr_m);
    chk("req_ready", 64'(req_ready), 64'(1) << e_g);
    chk("m_valid_idle", 64'(m_valid), 64'(0));
    chk("resp_valid_idle", 64'(resp_valid), 64'(0));
    e_write = req_write[e_g];
    e_burst = req_burst[e_g];
    e_addr  = req_addr[e_g*AW +: AW];
    e_wdata = req_wdata[e_g*DW +: DW];
    e_mask  = req_mask[e_g*2 +: 2];
    e_len   = e_burst ? req_len[e_g*LW +: LW] : 8'd0;
    @(posedge clock); #1;
    if (!keep) req_valid = '0;
    rand_fields(mode);
  endtask

  task automatic cmd_checks(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'(1));
    chk({tag, "_m_addr"},  64'(m_addr),  64'(e_addr));
    chk({tag, "_m_write"}, 64'(m_write), 64'(e_write));
    chk({tag, "_m_burst"}, 64'(m_burst), 64'(e_burst));
    chk({tag, "_m_wdata"}, 64'(m_wdata), 64'(e_wdata));
    chk({tag, "_m_mask"},  64'(m_mask),  64'(e_mask));
    chk({tag, "_m_len"},   64'(m_len),   64'(e_len));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  task automatic cmd_phase(input int delay);
    for (int c = 0; c < delay; c++) begin
      m_ready  = 1'b0;
      m_rvalid = 1'($urandom_range(0, 1));
      m_rdata  = $urandom;
      #1;
      cmd_checks("cmd_wait");
      chk("cmd_wait_resp_valid", 64'(resp_valid), 64'(0));
      @(posedge clock); #1;
    end
    m_rvalid = 1'b0;
    m_ready  = 1'b1;
    #1;
    cmd_checks("cmd_hs");
    if (e_write) begin
      chk("wr_resp_valid", 64'(resp_valid), 64'(1) << e_g);
      chk("wr_resp_last", 64'(resp_last), 64'(1));
    end else begin
      chk("rd_hs_resp_valid", 64'(resp_valid), 64'(0));
    end
    @(posedge clock); #1;
    m_ready = 1'b0;
    if (e_write) ptr_m = (e_g + 1) % N;
  endtask

  task automatic resp_phase(input int rlast_at, input bit seq, input logic [31:0] dbase);
    int          limit;
    logic [31:0] d;
    bit          last;
    limit = int'(e_len) + 1;
    for (int i = 0; i < limit; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        #1;
        chk("gap_resp_valid", 64'(resp_valid), 64'(0));
        chk("gap_resp_data", 64'(resp_data), 64'(0));
        @(posedge clock); #1;
      end
      d        = seq ? dbase + 32'(i) : $urandom;
      m_rvalid = 1'b1;
      m_rdata  = d;
      m_rlast  = (i == rlast_at);
      #1;
      last = (i == rlast_at) || (i == limit - 1);
      chk("beat_resp_valid", 64'(resp_valid), 64'(1) << e_g);
      chk("beat_resp_data", 64'(resp_data), 64'(d));
      chk("beat_resp_last", 64'(resp_last), 64'(last));
      @(posedge clock); #1;
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      if (last) break;
    end
    ptr_m = (e_g + 1) % N;
  endtask

  task automatic stray();
    req_valid = '0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    m_rdata   = $urandom;
    #1;
    chk("stray_resp_valid", 64'(resp_valid), 64'(0));
    chk("stray_resp_data", 64'(resp_data), 64'(0));
    chk("stray_m_valid", 64'(m_valid), 64'(0));
    @(posedge clock); #1;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic txn(input logic [3:0] v, input int mode, input int delay, input int rlast_at);
    rand_fields(mode);
    grant(v, 1'b0, mode);
    cmd_phase(delay);
    if (!e_write) resp_phase(rlast_at, 1'b0, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_burst = '0;
    req_addr = '0; req_wdata = '0; req_mask = '0; req_len = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_m_len", 64'(m_len), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    @(posedge clock); #1;
    req_valid = '0;
    reset = 1'b0;
    @(posedge clock); #1;

    // Continuous write requests from 0 and 1: alternate grants, one pulse per two cycles
    rand_fields(1);
    for (int k = 0; k < 4; k++) begin
      grant(4'b0011, 1'b1, 1);
      cmd_phase(0);
    end
    req_valid = '0;

    // Directed 4-beat read burst from requester 0
    rand_fields(2);
    req_addr[31:0] = 32'h8000_0000;
    req_burst[0]   = 1'b1;
    req_len[7:0]   = 8'd3;
    grant(4'b0001, 1'b0, 2);
    chk("dir_rd_addr", 64'(e_addr), 64'h8000_0000);
    cmd_phase(1);
    resp_phase(3, 1'b1, 32'hA);

    // Write stalled by m_ready for five cycles
    rand_fields(1);
    grant(4'b0100, 1'b0, 1);
    cmd_phase(5);

    // Reset asserted mid-burst after two of four beats
    rand_fields(2);
    req_burst[2] = 1'b1;
    req_len[2*LW +: LW] = 8'd3;
    grant(4'b0100, 1'b0, 2);
    cmd_phase(0);
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = $urandom;
      #1;
      chk("pre_rst_beat", 64'(resp_valid), 64'(1) << e_g);
      @(posedge clock); #1;
    end
    m_rvalid = 1'b1;
    m_rdata  = $urandom;
    #1;
    chk("pre_rst_beat3", 64'(resp_valid), 64'(1) << e_g);
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("async_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("async_rst_resp_data", 64'(resp_data), 64'(0));
    chk("async_rst_resp_last", 64'(resp_last), 64'(0));
    chk("async_rst_req_ready", 64'(req_ready), 64'(0));
    chk("async_rst_m_addr", 64'(m_addr), 64'(0));
    chk("async_rst_m_len", 64'(m_len), 64'(0));
    chk("async_rst_m_burst", 64'(m_burst), 64'(0));
    @(posedge clock); #1;
    m_rvalid = 1'b0;
    reset = 1'b0;
    ptr_m = 0;
    txn(4'b1111, 0, 0, 1);

    stray();

    // Wrap from the top requester back to 0, then simultaneous 0 and 2
    txn(4'b1000, 0, 0, 0);
    txn(4'b0001, 0, 1, 5);
    txn(4'b0101, 0, 0, 2);
    txn(4'b0101, 0, 0, 2);

    for (int n = 0; n < 40; n++) begin
      txn(4'($urandom_range(1, 15)), 0, $urandom_range(0, 3), $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) stray();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
